paddle_gen: RTL and testbench



---
 rtl/paddle_gen.sv | 130 +++++++++++++
 tb/tb_paddle_gen.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/paddle_gen.sv
// rtl/paddle_gen.sv - player paddle position, video bit and hit-segment generator
module paddle_gen #(
    parameter int H_START    = 32,
    parameter int PAD_WIDTH  = 4,
    parameter int PAD_HEIGHT = 16,
    parameter int V_MIN      = 16,
    parameter int V_MAX      = 240,
    parameter int STEP       = 2
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic [8:0] hcount,
    input  logic [8:0] vcount,
    input  logic       hblank,
    input  logic       vblank,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [8:0] pad_top,
    output logic       paddle_video,
    output logic [2:0] pad_seg
);

    localparam logic [9:0] TOP_RESET = 10'((V_MIN + V_MAX - PAD_HEIGHT) / 2);
    localparam logic [9:0] TOP_MIN   = 10'(V_MIN);
    localparam logic [9:0] TOP_MAX   = 10'(V_MAX - PAD_HEIGHT);
    localparam logic [9:0] STEP_W    = 10'(STEP);
    localparam logic [9:0] H_LO      = 10'(H_START);
    localparam logic [9:0] H_HI      = 10'(H_START + PAD_WIDTH);
    localparam logic [9:0] HEIGHT_W  = 10'(PAD_HEIGHT);
    localparam int         SEG_SHIFT = $clog2(PAD_HEIGHT / 8);

    logic       up_meta;
    logic       up_s;
    logic       dn_meta;
    logic       dn_s;
    logic       vblank_d;
    logic       tick;

    logic [9:0] top_w;
    logic [9:0] hcount_w;
    logic [9:0] vcount_w;
    logic [8:0] top_up;
    logic [8:0] top_dn;
    logic [8:0] top_next;
    logic       in_h;
    logic       in_v;
    logic [2:0] seg_next;

    // Buttons are asynchronous to the pixel clock: two-flop synchronizers.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            up_meta <= 1'b0;
            up_s    <= 1'b0;
            dn_meta <= 1'b0;
            dn_s    <= 1'b0;
        end else begin
            up_meta <= btn_up;
            up_s    <= up_meta;
            dn_meta <= btn_down;
            dn_s    <= dn_meta;
        end
    end

    // vblank_d resets high so a vblank already high at release is not a frame start.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            vblank_d <= 1'b1;
        end else begin
            vblank_d <= vblank;
        end
    end

    assign tick     = vblank & ~vblank_d;
    assign top_w    = {1'b0, pad_top};
    assign hcount_w = {1'b0, hcount};
    assign vcount_w = {1'b0, vcount};

    // Saturating moves in 10 bits so the up limit cannot underflow.
    always_comb begin
        top_up = 9'(top_w - STEP_W);
        if (top_w < TOP_MIN + STEP_W) begin
            top_up = 9'(TOP_MIN);
        end
        top_dn = 9'(top_w + STEP_W);
        if (top_w + STEP_W > TOP_MAX) begin
            top_dn = 9'(TOP_MAX);
        end
    end

    always_comb begin
        top_next = pad_top;
        if (tick) begin
            case ({up_s, dn_s})
                2'b10:   top_next = top_up;
                2'b01:   top_next = top_dn;
                default: top_next = pad_top;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            pad_top <= 9'(TOP_RESET);
        end else begin
            pad_top <= top_next;
        end
    end

    assign in_h = (hcount_w >= H_LO) && (hcount_w < H_HI);
    assign in_v = (vcount_w >= top_w) && (vcount_w < top_w + HEIGHT_W);

    // Eight equal segments over the paddle height; height is a power of two.
    always_comb begin
        seg_next = 3'd0;
        if (in_v) begin
            seg_next = 3'((vcount_w - top_w) >> SEG_SHIFT);
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            paddle_video <= 1'b0;
            pad_seg      <= 3'd0;
        end else begin
            paddle_video <= in_h & in_v & ~hblank & ~vblank;
            pad_seg      <= seg_next;
        end
    end

endmodule

// File: tb/tb_paddle_gen.sv
// tb/tb_paddle_gen.sv - self-checking bench for paddle_gen with a frame-level model
`timescale 1ns/1ps
module tb_paddle_gen;

    localparam int M_RESET = 120;
    localparam int M_MIN   = 16;
    localparam int M_MAX   = 224;
    localparam int M_STEP  = 2;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic [8:0] hcount = 9'd0;
    logic [8:0] vcount = 9'd0;
    logic       hblank = 1'b0;
    logic       vblank = 1'b1;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic [8:0] pad_top;
    logic       paddle_video;
    logic [2:0] pad_seg;

    int n_tests = 0;
    int n_fail = 0;

    int m_pad = 0;
    int m_video = 0;
    int m_seg = 0;
    bit m_valid = 0;
    bit up_hist[2];
    bit dn_hist[2];
    bit prev_vb = 1;
    bit m_tick;
    bit m_up;
    bit m_dn;
    bit m_in_v;
    int old_top;

    int         lit_id = 0;
    int         done_id = 0;
    logic [2:0] lit_mask = 3'd0;
    int         lit_pad = 0;
    int         lit_video = 0;
    int         lit_seg = 0;
    string      lit_name = "";

    always #5 clk = ~clk;

    paddle_gen dut (
        .clk          (clk),
        .nreset       (nreset),
        .hcount       (hcount),
        .vcount       (vcount),
        .hblank       (hblank),
        .vblank       (vblank),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .pad_top      (pad_top),
        .paddle_video (paddle_video),
        .pad_seg      (pad_seg)
    );

    // Frame-level model: buttons seen two edges late, one move per vblank rise.
    always @(posedge clk) begin
        if (!nreset) begin
            m_pad      = M_RESET;
            m_video    = 0;
            m_seg      = 0;
            up_hist[0] = 0;
            up_hist[1] = 0;
            dn_hist[0] = 0;
            dn_hist[1] = 0;
            prev_vb    = 1;
            m_valid    = 1;
        end else begin
            m_up    = up_hist[1];
            m_dn    = dn_hist[1];
            m_tick  = vblank && !prev_vb;
            old_top = m_pad;
            m_in_v  = (int'(vcount) >= old_top) && (int'(vcount) < old_top + 16);
            m_video = (int'(hcount) >= 32 && int'(hcount) < 36 && m_in_v && !hblank && !vblank) ? 1 : 0;
            m_seg   = m_in_v ? (int'(vcount) - old_top) / 2 : 0;
            if (m_tick && m_up && !m_dn) begin
                m_pad = (old_top - M_STEP < M_MIN) ? M_MIN : old_top - M_STEP;
            end else if (m_tick && m_dn && !m_up) begin
                m_pad = (old_top + M_STEP > M_MAX) ? M_MAX : old_top + M_STEP;
            end
            up_hist[1] = up_hist[0];
            up_hist[0] = btn_up;
            dn_hist[1] = dn_hist[0];
            dn_hist[0] = btn_down;
            prev_vb    = vblank;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            n_tests += 3;
            if (pad_top !== 9'(m_pad)) begin
                n_fail++;
                $display("FAIL model_pad_top t=%0t got %0d want %0d", $time, pad_top, m_pad);
            end
            if (paddle_video !== 1'(m_video)) begin
                n_fail++;
                $display("FAIL model_video t=%0t got %0b want %0d", $time, paddle_video, m_video);
            end
            if (pad_seg !== 3'(m_seg)) begin
                n_fail++;
                $display("FAIL model_seg t=%0t got %0d want %0d", $time, pad_seg, m_seg);
            end
        end
        if (lit_id != done_id) begin
            done_id = lit_id;
            if (lit_mask[0]) begin
                n_tests++;
                if (pad_top !== 9'(lit_pad)) begin
                    n_fail++;
                    $display("FAIL %s pad_top got %0d want %0d", lit_name, pad_top, lit_pad);
                end
            end
            if (lit_mask[1]) begin
                n_tests++;
                if (paddle_video !== 1'(lit_video)) begin
                    n_fail++;
                    $display("FAIL %s video got %0b want %0d", lit_name, paddle_video, lit_video);
                end
            end
            if (lit_mask[2]) begin
                n_tests++;
                if (pad_seg !== 3'(lit_seg)) begin
                    n_fail++;
                    $display("FAIL %s seg got %0d want %0d", lit_name, pad_seg, lit_seg);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_lit(input string name, input logic [2:0] mask, input int p, input int v, input int s);
        lit_name  = name;
        lit_mask  = mask;
        lit_pad   = p;
        lit_video = v;
        lit_seg   = s;
        lit_id++;
        @(negedge clk);
        #1;
    endtask

    task automatic frame();
        vblank = 1'b0;
        repeat (4) step();
        vblank = 1'b1;
        repeat (4) step();
    endtask

    task automatic reset_dut();
        nreset = 1'b0;
        repeat (3) step();
        nreset = 1'b1;
        step();
    endtask

    initial begin
        // Release reset with vblank high and up held: no move may follow.
        nreset = 1'b0;
        vblank = 1'b1;
        btn_up = 1'b1;
        repeat (3) step();
        nreset = 1'b1;
        repeat (4) step();
        expect_lit("reset_state", 3'b111, 120, 0, 0);

        frame();
        expect_lit("up_tick1", 3'b001, 118, 0, 0);
        frame();
        expect_lit("up_tick2", 3'b001, 116, 0, 0);
        frame();
        expect_lit("up_tick3", 3'b001, 114, 0, 0);

        btn_up   = 1'b0;
        btn_down = 1'b1;
        reset_dut();
        repeat (60) frame();
        expect_lit("down_saturate", 3'b001, 224, 0, 0);

        btn_down = 1'b0;
        btn_up   = 1'b1;
        reset_dut();
        repeat (60) frame();
        expect_lit("up_saturate", 3'b001, 16, 0, 0);

        btn_down = 1'b1;
        reset_dut();
        repeat (5) frame();
        expect_lit("both_held", 3'b001, 120, 0, 0);

        btn_up   = 1'b0;
        btn_down = 1'b0;
        reset_dut();
        vblank = 1'b0;
        repeat (4) step();
        vblank = 1'b1;
        btn_up = 1'b1;
        step();
        btn_up = 1'b0;
        repeat (4) step();
        expect_lit("pulse_at_tick", 3'b001, 120, 0, 0);

        reset_dut();
        vblank = 1'b0;
        hblank = 1'b0;
        for (int v = 116; v < 140; v++) begin
            for (int h = 28; h < 40; h++) begin
                vcount = 9'(v);
                hcount = 9'(h);
                step();
                if (v == 120 && h == 32) expect_lit("sweep_120_32", 3'b110, 0, 1, 0);
                else if (v == 121 && h == 33) expect_lit("sweep_121_33", 3'b110, 0, 1, 0);
                else if (v == 126 && h == 34) expect_lit("sweep_126_34", 3'b110, 0, 1, 3);
                else if (v == 127 && h == 31) expect_lit("sweep_127_31", 3'b110, 0, 0, 3);
                else if (v == 134 && h == 35) expect_lit("sweep_134_35", 3'b110, 0, 1, 7);
                else if (v == 135 && h == 32) expect_lit("sweep_135_32", 3'b110, 0, 1, 7);
                else if (v == 136 && h == 32) expect_lit("sweep_136_32", 3'b110, 0, 0, 0);
                else if (v == 120 && h == 36) expect_lit("sweep_120_36", 3'b110, 0, 0, 0);
            end
        end

        vcount = 9'd125;
        hcount = 9'd33;
        hblank = 1'b1;
        step();
        expect_lit("hblank_cut", 3'b110, 0, 0, 2);
        hblank = 1'b0;
        step();
        expect_lit("hblank_release", 3'b110, 0, 1, 2);

        repeat (2) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
